// File: rtl/n64_poll_ctrl.sv
// n64_poll_ctrl: sends the 8-bit poll command plus the console stop bit on the
// open-drain N64 data line, then captures the controller's reply MSB first.
// Ports: clk/rst (async, active-high); start = poll request taken in IDLE;
// data_in = raw pad level; data_oe = 1 pulls the line low; busy = poll in
// progress; valid/timeout = one-cycle result pulses; buttons = last good reply.
module n64_poll_ctrl #(
  parameter int         US_TICKS   = 12,
  parameter logic [7:0] CMD        = 8'h01,
  parameter int         RX_BITS    = 32,
  parameter int         TIMEOUT_US = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        data_in,
  output logic        data_oe,
  output logic        busy,
  output logic        valid,
  output logic        timeout,
  output logic [31:0] buttons
);

  localparam int TO_CYC = TIMEOUT_US * US_TICKS;
  localparam int CELL   = 4 * US_TICKS;
  localparam int MAXC   = (TO_CYC > CELL) ? TO_CYC : CELL;
  localparam int TW     = $clog2(MAXC + 1);
  localparam int CW     = $clog2(RX_BITS + 1);

  localparam logic [TW-1:0] CELL_LAST = TW'(CELL - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(3 * US_TICKS - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(2 * US_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(US_TICKS);
  localparam logic [TW-1:0] T_THREE   = TW'(3 * US_TICKS);
  localparam logic [CW-1:0] BITS_LAST = CW'(RX_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_SAMPLE, RX_HIGH, DONE, GUARD
  } state_t;

  state_t        state;
  logic [TW-1:0] tick;
  logic [TW-1:0] tick_nxt;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic [31:0]   rx;
  logic          sync_meta;
  logic          sync_line;
  logic          line_prev;
  logic          fall;

  assign tick_nxt = tick + 1'b1;
  assign fall     = line_prev & ~sync_line;

  // Idle line is pulled up, so the synchroniser resets to 1 to avoid a
  // phantom falling edge right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b1;
      sync_line <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync_meta <= data_in;
      sync_line <= sync_meta;
      line_prev <= sync_line;
    end
  end

  // data_oe is registered and computed from the tick value of the next
  // cycle, so the line level always matches the tick the cell is in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tick    <= '0;
      idx     <= '0;
      cnt     <= '0;
      rx      <= '0;
      data_oe <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      buttons <= '0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= TX_BIT;
            idx     <= 3'd7;
            tick    <= '0;
            data_oe <= 1'b1;
            busy    <= 1'b1;
          end
        end
        TX_BIT: begin
          if (tick == CELL_LAST) begin
            tick    <= '0;
            data_oe <= 1'b1;
            if (idx == 3'd0) state <= TX_STOP;
            else             idx   <= idx - 1'b1;
          end else begin
            tick    <= tick_nxt;
            data_oe <= (tick_nxt < (CMD[idx] ? T_ONE : T_THREE));
          end
        end
        TX_STOP: begin
          if (tick == STOP_LAST) begin
            state   <= RX_WAIT;
            tick    <= '0;
            cnt     <= '0;
            rx      <= '0;
            data_oe <= 1'b0;
          end else begin
            tick    <= tick_nxt;
            data_oe <= (tick_nxt < T_ONE);
          end
        end
        RX_WAIT: begin
          if (fall) begin
            state <= RX_SAMPLE;
            tick  <= '0;
          end else if (tick == TO_LAST) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            tick <= tick_nxt;
          end
        end
        RX_SAMPLE: begin
          if (tick == HALF_LAST) begin
            rx    <= {rx[30:0], sync_line};
            cnt   <= cnt + 1'b1;
            tick  <= '0;
            state <= (cnt == BITS_LAST) ? DONE : RX_HIGH;
          end else begin
            tick <= tick_nxt;
          end
        end
        RX_HIGH: begin
          if (sync_line) begin
            state <= RX_WAIT;
            tick  <= '0;
          end else if (tick == TO_LAST) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            tick <= tick_nxt;
          end
        end
        DONE: begin
          buttons <= rx;
          valid   <= 1'b1;
          tick    <= '0;
          state   <= GUARD;
        end
        GUARD: begin
          // Controller stop bit: wait for a full cell of continuous high.
          if (!sync_line) begin
            tick <= '0;
          end else if (tick == CELL_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tick <= tick_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_poll_ctrl.sv
// tb_n64_poll_ctrl: drives n64_poll_ctrl with a behavioural controller model on
// a wired-AND line and checks the command waveform, replies and timeouts.
module tb_n64_poll_ctrl;
  localparam int         U     = 4;
  localparam int         T     = 100 * U;
  localparam logic [7:0] CMD_B = 8'h01;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ctrl_low;
  logic        data_in;
  logic        data_oe;
  logic        busy;
  logic        valid;
  logic        timeout;
  logic [31:0] buttons;

  assign data_in = ~(data_oe | ctrl_low);

  always #5 clk = ~clk;

  n64_poll_ctrl #(.US_TICKS(U), .CMD(CMD_B), .RX_BITS(32), .TIMEOUT_US(100)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .data_oe(data_oe),
    .busy(busy), .valid(valid), .timeout(timeout), .buttons(buttons)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [31:0] model_buttons = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: records pulse geometry and result events.
  int   pulses = 0;
  int   rise_c[9];
  int   len_c[9];
  int   rel_cyc = 0;
  int   valid_cnt = 0, valid_cyc = 0;
  int   to_cnt = 0, to_cyc = 0;
  int   busy_fall_cyc = 0;
  int   oe_viol = 0, both_viol = 0;
  logic prev_oe = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      pulses    = 0;
      prev_oe   = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (data_oe && !prev_oe) begin
        if (pulses >= 9) oe_viol++;
        else rise_c[pulses] = cyc;
        pulses++;
      end
      if (!data_oe && prev_oe && pulses <= 9 && pulses > 0) begin
        len_c[pulses-1] = cyc - rise_c[pulses-1];
        if (pulses == 9) rel_cyc = cyc;
      end
      if (data_oe && !busy) oe_viol++;
      if (valid) begin valid_cnt++; valid_cyc = cyc; end
      if (timeout) begin to_cnt++; to_cyc = cyc; end
      if (valid && timeout) both_viol++;
      if (prev_busy && !busy) begin busy_fall_cyc = cyc; pulses = 0; end
      prev_oe   = data_oe;
      prev_busy = busy;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (busy && pulses == 9 && !data_oe) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      step();
    end
  endtask

  // Controller reply: each bit is a 4 us cell, low 1 us for a 1, 3 us for a 0.
  task automatic send_bits(input logic [31:0] w, input int n, output int lf, output logic lastbit);
    lf = 0;
    lastbit = 1'b0;
    for (int b = 0; b < n; b++) begin
      logic v;
      v = w[31-b];
      ctrl_low = 1'b1;
      lf = cyc;
      lastbit = v;
      for (int k = 0; k < (v ? U : 3*U); k++) step();
      ctrl_low = 1'b0;
      for (int k = 0; k < (v ? 3*U : U); k++) step();
    end
  endtask

  task automatic send_stop(output int rel);
    ctrl_low = 1'b1;
    repeat (2*U) step();
    ctrl_low = 1'b0;
    rel = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ctrl_low = 1'b0;
    repeat (3) step();
    tests++; if (data_oe !== 1'b0) begin fails++; $display("FAIL reset_oe: got %b want 0", data_oe); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    tests++; if (buttons !== 32'h0) begin fails++; $display("FAIL reset_buttons: got %h want 0", buttons); end
    rst = 1'b0;
    repeat (3) step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_cmd_waveform();
    int  to0, v0, ov0;
    bit  ok;
    to0 = to_cnt; v0 = valid_cnt; ov0 = oe_viol;
    do_start();
    tests++; if (busy !== 1'b1 || data_oe !== 1'b1) begin
      fails++; $display("FAIL cmd_first_cycle: busy=%b oe=%b want 1 1", busy, data_oe);
    end
    ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (to_cnt != to0) begin ok = 1'b1; break; end
      step();
    end
    tests++; if (!ok) begin fails++; $display("FAIL cmd_timeout_wait: no timeout pulse within bound"); end
    for (int i = 0; i < 9; i++) begin
      int exp_len;
      exp_len = (i == 8) ? U : (CMD_B[7-i] ? U : 3*U);
      tests++;
      if (len_c[i] !== exp_len || (rise_c[i] - rise_c[0]) !== 4*U*i) begin
        fails++; $display("FAIL cmd_cell%0d: low=%0d start=%0d want low=%0d start=%0d",
                          i, len_c[i], rise_c[i]-rise_c[0], exp_len, 4*U*i);
      end
    end
    tests++; if (to_cyc - rel_cyc !== 2*U + T) begin
      fails++; $display("FAIL cmd_timeout_time: got %0d want %0d", to_cyc - rel_cyc, 2*U + T);
    end
    tests++; if (to_cnt - to0 !== 1 || valid_cnt !== v0) begin
      fails++; $display("FAIL cmd_pulses: timeouts=%0d valids=%0d want 1 0", to_cnt - to0, valid_cnt - v0);
    end
    tests++; if (busy !== 1'b0 || buttons !== model_buttons) begin
      fails++; $display("FAIL cmd_after: busy=%b buttons=%h want 0 %h", busy, buttons, model_buttons);
    end
    tests++; if (oe_viol !== ov0) begin fails++; $display("FAIL cmd_glitch: got %0d want %0d", oe_viol, ov0); end
    repeat (5) step();
  endtask

  task automatic test_reset_mid_tx();
    bit ok;
    int to0;
    do_start();
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (pulses == 5) begin ok = 1'b1; break; end
      step();
    end
    tests++; if (!ok) begin fails++; $display("FAIL rst_tx_wait: idx 3 cell not reached"); end
    repeat (2) step();
    rst = 1'b1;
    #1;
    tests++; if (data_oe !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_tx_release: oe=%b busy=%b want 0 0", data_oe, busy);
    end
    tests++; if (buttons !== model_buttons) begin
      fails++; $display("FAIL rst_tx_buttons: got %h want %h", buttons, model_buttons);
    end
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    to0 = to_cnt;
    do_start();
    ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (to_cnt != to0) begin ok = 1'b1; break; end
      step();
    end
    tests++; if (!ok) begin fails++; $display("FAIL rst_tx_repoll: no timeout after new poll"); end
    for (int i = 0; i < 9; i++) begin
      int exp_len;
      exp_len = (i == 8) ? U : (CMD_B[7-i] ? U : 3*U);
      tests++;
      if (len_c[i] !== exp_len || (rise_c[i] - rise_c[0]) !== 4*U*i) begin
        fails++; $display("FAIL rst_tx_cell%0d: low=%0d start=%0d want low=%0d start=%0d",
                          i, len_c[i], rise_c[i]-rise_c[0], exp_len, 4*U*i);
      end
    end
    repeat (5) step();
  endtask

  task automatic test_good_reply();
    for (int n = 0; n < 3; n++) begin
      logic [31:0] w;
      logic        lb;
      int          v0, to0, ov0, bv0, lf, rel;
      bit          ok;
      w = (n == 0) ? 32'hA5C3_0F81 : $urandom;
      v0 = valid_cnt; to0 = to_cnt; ov0 = oe_viol; bv0 = both_viol;
      do_start();
      wait_release(ok);
      tests++; if (!ok) begin fails++; $display("FAIL good%0d_release: stop bit never released", n); end
      repeat (2*U + $urandom_range(2, 10)) step();
      send_bits(w, 32, lf, lb);
      send_stop(rel);
      wait_idle(ok);
      tests++; if (!ok) begin fails++; $display("FAIL good%0d_idle: busy stuck high", n); end
      model_buttons = w;
      tests++; if (buttons !== model_buttons) begin
        fails++; $display("FAIL good%0d_buttons: got %h want %h", n, buttons, model_buttons);
      end
      tests++; if (valid_cnt - v0 !== 1 || to_cnt !== to0) begin
        fails++; $display("FAIL good%0d_pulses: valids=%0d timeouts=%0d want 1 0", n, valid_cnt - v0, to_cnt - to0);
      end
      tests++; if (valid_cyc - lf < 2*U + 2 || valid_cyc - lf > 2*U + 6) begin
        fails++; $display("FAIL good%0d_valid_time: got %0d want %0d..%0d", n, valid_cyc - lf, 2*U+2, 2*U+6);
      end
      tests++; if (busy_fall_cyc - rel !== 4*U + 2) begin
        fails++; $display("FAIL good%0d_guard: got %0d want %0d", n, busy_fall_cyc - rel, 4*U + 2);
      end
      tests++; if (oe_viol !== ov0 || both_viol !== bv0) begin
        fails++; $display("FAIL good%0d_glitch: oe_viol=%0d both=%0d want %0d %0d", n, oe_viol, both_viol, ov0, bv0);
      end
      repeat ($urandom_range(2, 8)) step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1;
    logic        lb;
    int          v0, ov0, lf, rel;
    bit          ok;
    w1 = $urandom;
    v0 = valid_cnt; ov0 = oe_viol;
    start = 1'b1;
    step();
    wait_release(ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_release: stop bit never released"); end
    repeat (2*U + $urandom_range(2, 10)) step();
    send_bits(w1, 32, lf, lb);
    start = 1'b0;
    send_stop(rel);
    wait_idle(ok);
    model_buttons = w1;
    tests++; if (!ok || buttons !== model_buttons || valid_cnt - v0 !== 1) begin
      fails++; $display("FAIL b2b_first: buttons=%h valids=%0d want %h 1", buttons, valid_cnt - v0, model_buttons);
    end
    repeat (3) step();
    tests++; if (busy !== 1'b0 || oe_viol !== ov0) begin
      fails++; $display("FAIL b2b_held_start: busy=%b oe_viol=%0d want 0 %0d", busy, oe_viol, ov0);
    end
    v0 = valid_cnt;
    do_start();
    wait_release(ok);
    repeat (2*U + $urandom_range(2, 10)) step();
    send_bits(32'h0000_0001, 32, lf, lb);
    send_stop(rel);
    wait_idle(ok);
    model_buttons = 32'h0000_0001;
    tests++; if (!ok || buttons !== model_buttons || valid_cnt - v0 !== 1) begin
      fails++; $display("FAIL b2b_second: buttons=%h valids=%0d want %h 1", buttons, valid_cnt - v0, model_buttons);
    end
    repeat (5) step();
  endtask

  task automatic test_missing_reply();
    logic [31:0] w;
    logic        lb;
    int          v0, to0, ov0, lf, exp_to;
    bit          ok;
    w = $urandom;
    v0 = valid_cnt; to0 = to_cnt; ov0 = oe_viol;
    do_start();
    wait_release(ok);
    repeat (2*U + $urandom_range(2, 10)) step();
    send_bits(w, 17, lf, lb);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (to_cnt != to0) begin ok = 1'b1; break; end
      step();
    end
    tests++; if (!ok) begin fails++; $display("FAIL miss_wait: no timeout pulse within bound"); end
    exp_to = lf + (lb ? 2*U + 4 : 3*U + 3) + T;
    tests++; if (to_cyc < exp_to - 2 || to_cyc > exp_to + 2) begin
      fails++; $display("FAIL miss_timeout_time: got %0d want %0d+-2", to_cyc - lf, exp_to - lf);
    end
    tests++; if (buttons !== model_buttons || valid_cnt !== v0 || busy !== 1'b0) begin
      fails++; $display("FAIL miss_result: buttons=%h valids=%0d busy=%b want %h 0 0",
                        buttons, valid_cnt - v0, busy, model_buttons);
    end
    tests++; if (oe_viol !== ov0 || both_viol !== 0) begin
      fails++; $display("FAIL miss_glitch: oe_viol=%0d both=%0d want %0d 0", oe_viol, both_viol, ov0);
    end
  endtask

  initial begin
    test_reset();
    test_cmd_waveform();
    test_reset_mid_tx();
    test_good_reply();
    test_back_to_back();
    test_missing_reply();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
